serial_code_receiver: RTL
=========================

Name: serial_code_receiver

Overview:
- Upstream stage of the parity checker. Deserialises one asynchronous-style serial frame into the 9-bit CODE word (8 data bits plus the received parity bit).
- Frame format: start bit, 8 data bits LSB first, parity bit, stop bit.
- Presents the word on CODE with a one-cycle DONE strobe, which is exactly the DONE/CODE pair the parity checker consumes.
- Parity is not evaluated here. The parity bit is passed through unchanged.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per serial bit period (even, >= 4).
- DATA_BITS, 8, data bits per frame; CODE width = DATA_BITS+1.

Ports:
- clock  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- RX  input  1  serial line, idle high
- CODE  output  DATA_BITS+1  {parity_bit, data[DATA_BITS-1:0]}, data[0] = first data bit received
- DONE  output  1  one-cycle strobe: CODE updated with a valid frame
- FRAME_ERR  output  1  one-cycle strobe: stop bit sampled low
- BUSY  output  1  high whenever state != IDLE

Behaviour:
- Interface (already decided): one clock, named clock; reset is synchronous and active-high, named reset.
- Reset values: CODE=0, DONE=0, FRAME_ERR=0, BUSY=0, state=IDLE, bit counter=0, cycle counter=0.
- States and transitions:
  - IDLE: RX==0 -> START, cycle counter cleared.
  - START: after CLKS_PER_BIT/2 cycles, sample RX (mid start bit).
    - RX==0 -> DATA, counters cleared.
    - RX==1 -> IDLE. Treated as a glitch; no strobe.
  - DATA: every CLKS_PER_BIT cycles, sample RX into the shift register, LSB first. After the DATA_BITS-th sample -> PARITY.
  - PARITY: after CLKS_PER_BIT cycles, sample RX into the parity holding bit -> STOP.
  - STOP: after CLKS_PER_BIT cycles, sample RX.
    - RX==1: CODE <= {parity, data} on the next edge; DONE=1 for exactly that cycle; -> IDLE.
    - RX==0: FRAME_ERR=1 for one cycle; CODE unchanged; no DONE; -> WAIT_IDLE.
  - WAIT_IDLE: stay until RX==1, then -> IDLE. This prevents a stuck-low line from being decoded as back-to-back frames.
- Timing:
  - Sampling instants are mid-bit: start-edge detect + CLKS_PER_BIT/2 + k*CLKS_PER_BIT.
  - Latency: DONE rises 1 cycle after the stop-bit sample, i.e. (DATA_BITS+2)*CLKS_PER_BIT + CLKS_PER_BIT/2 + 1 cycles after the first cycle RX is seen low.
- Output holding:
  - CODE holds its value between DONE strobes. Partial frames never alter CODE.
  - DONE and FRAME_ERR are mutually exclusive and never asserted in consecutive cycles for the same frame.
- Back-to-back frames: a new start bit may begin immediately after the stop-bit sample. IDLE detects RX==0 on the cycle after returning.
- Reset mid-frame: the frame is abandoned with no strobe, outputs go to reset values, and the next falling RX starts a fresh frame.
- RX changes between sample instants are ignored. Only mid-bit samples matter, except falling-edge detection in IDLE.

Optional Feature:
- RX_SYNC_EN
  - Defined: RX passes through a 2-flop synchroniser, reset to 1, before the FSM. All latencies grow by 2 cycles.
  - Undefined: RX feeds the FSM directly. For benches and for RX that is already synchronous.

Decomposition:
- Shared package:
  - state encoding typedef (IDLE, START, DATA, PARITY, STOP, WAIT_IDLE)
  - CODE_W = DATA_BITS+1 constant
  - default CLKS_PER_BIT
- The parity checker imports the same CODE_W.
- One natural sub-module: bit_timer. It holds the cycle counter, has a clear input and a half/full-period tick output, and is parameterised by CLKS_PER_BIT.

Test Plan:
- CLKS_PER_BIT=4: send data 0x1C, parity bit 1, stop 1 -> one DONE pulse, CODE=9'h11C, FRAME_ERR=0, DONE exactly 43 cycles after the start edge.
- Send 0x1B, parity 0, stop 1, immediately followed by 0xA5, parity 1, stop 1 -> two DONE pulses, CODE=9'h01B then 9'h1A5, no idle gap required.
- Send 0x55 with stop bit 0, RX held low for 10 more cycles -> FRAME_ERR pulse, CODE keeps its previous value, no DONE, BUSY stays high until RX returns to 1.
- RX low for 1 cycle only, a glitch shorter than CLKS_PER_BIT/2 -> back to IDLE, no DONE/FRAME_ERR, CODE unchanged.
- Assert reset during data bit 4 of a frame -> all outputs 0 next cycle, no strobe. Then send a full frame 0x3C, parity 0 -> CODE=9'h03C, DONE once.
- With RX_SYNC_EN defined, repeat the first test -> same CODE=9'h11C, DONE 2 cycles later than without the macro.

Source files
------------

// File: rtl/serial_code_receiver_pkg.sv
// Shared types and constants for the serial code receiver and the downstream parity checker.
package serial_code_receiver_pkg;

   localparam int DEF_CLKS_PER_BIT = 16;
   localparam int DEF_DATA_BITS    = 8;
   localparam int CODE_W           = DEF_DATA_BITS + 1;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      WAIT_IDLE
   } state_t;

endpackage

// File: rtl/serial_code_receiver_bit_timer.sv
// Cycle counter for one serial bit period; flags the mid-start-bit and full-period sample points.
module serial_code_receiver_bit_timer #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   output logic half_tick,
   output logic full_tick
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt_reg;

   assign half_tick = (cnt_reg == HALF_LAST);
   assign full_tick = (cnt_reg == FULL_LAST);

   // Wraps on its own at the full period, so consecutive bit samples stay CLKS_PER_BIT apart.
   always_ff @(posedge clock) begin
      if (reset || clear) begin
         cnt_reg <= '0;
      end else if (full_tick) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_reg + 1'b1;
      end
   end

endmodule

// File: rtl/serial_code_receiver.sv
// Deserialises start/data(LSB first)/parity/stop frames into CODE = {parity, data} with DONE strobe.
// Define RX_SYNC_EN to insert a 2-flop synchroniser on RX (adds 2 cycles of latency).
module serial_code_receiver
   import serial_code_receiver_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
   parameter int DATA_BITS    = DEF_DATA_BITS
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 RX,
   output logic [DATA_BITS:0]   CODE,
   output logic                 DONE,
   output logic                 FRAME_ERR,
   output logic                 BUSY
);

   localparam int BW = $clog2(DATA_BITS + 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

   state_t                 state_reg;
   logic [BW-1:0]          bit_cnt_reg;
   logic [DATA_BITS-1:0]   shift_reg;
   logic                   parity_reg;
   logic                   rx_s;
   logic                   timer_clear;
   logic                   half_tick;
   logic                   full_tick;

`ifdef RX_SYNC_EN
   logic [1:0] sync_reg;

   always_ff @(posedge clock) begin
      if (reset) begin
         sync_reg <= 2'b11;
      end else begin
         sync_reg <= {sync_reg[0], RX};
      end
   end

   assign rx_s = sync_reg[1];
`else
   assign rx_s = RX;
`endif

   // Re-align the timer at the falling edge and again at mid start bit, so data samples land mid-bit.
   assign timer_clear = (state_reg == IDLE) || (state_reg == WAIT_IDLE) ||
                        ((state_reg == START) && half_tick);

   serial_code_receiver_bit_timer #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_bit_timer (
      .clock     (clock),
      .reset     (reset),
      .clear     (timer_clear),
      .half_tick (half_tick),
      .full_tick (full_tick)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg   <= IDLE;
         bit_cnt_reg <= '0;
         shift_reg   <= '0;
         parity_reg  <= 1'b0;
         CODE        <= '0;
         DONE        <= 1'b0;
         FRAME_ERR   <= 1'b0;
         BUSY        <= 1'b0;
      end else begin
         DONE      <= 1'b0;
         FRAME_ERR <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (!rx_s) begin
                  state_reg <= START;
                  BUSY      <= 1'b1;
               end
            end
            START: begin
               if (half_tick) begin
                  if (!rx_s) begin
                     state_reg   <= DATA;
                     bit_cnt_reg <= '0;
                  end else begin
                     state_reg <= IDLE;
                     BUSY      <= 1'b0;
                  end
               end
            end
            DATA: begin
               if (full_tick) begin
                  shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
                  if (bit_cnt_reg == LAST_BIT) begin
                     state_reg   <= PARITY;
                     bit_cnt_reg <= '0;
                  end else begin
                     bit_cnt_reg <= bit_cnt_reg + 1'b1;
                  end
               end
            end
            PARITY: begin
               if (full_tick) begin
                  parity_reg <= rx_s;
                  state_reg  <= STOP;
               end
            end
            STOP: begin
               if (full_tick) begin
                  if (rx_s) begin
                     CODE      <= {parity_reg, shift_reg};
                     DONE      <= 1'b1;
                     state_reg <= IDLE;
                     BUSY      <= 1'b0;
                  end else begin
                     FRAME_ERR <= 1'b1;
                     state_reg <= WAIT_IDLE;
                  end
               end
            end
            WAIT_IDLE: begin
               // A stuck-low line must return high before another start bit is accepted.
               if (rx_s) begin
                  state_reg <= IDLE;
                  BUSY      <= 1'b0;
               end
            end
            default: begin
               state_reg <= IDLE;
               BUSY      <= 1'b0;
            end
         endcase
      end
   end

endmodule
